// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift_sequencer slice:
//   - operation encodings (op 2'b11 is reserved and executes as logical)
//   - FSM state encoding (also exported on the debug state output)
//   - word widths
//   - bit_rev32 helper, used only when SHIFT_SEQ_LEFT_EN is defined
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    localparam int WORD_W  = 16;
    localparam int DWORD_W = 32;

    localparam logic [1:0] SHIFT_OP_LSR = 2'b00;
    localparam logic [1:0] SHIFT_OP_ASR = 2'b01;
    localparam logic [1:0] SHIFT_OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_A  = 2'd1,
        S_B  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Mirror a 32-bit word. A left shift is done as rev(rev(x) >> n).
    function automatic logic [DWORD_W-1:0] bit_rev32(input logic [DWORD_W-1:0] x);
        logic [DWORD_W-1:0] y;
        for (int i = 0; i < DWORD_W; i++) begin
            y[i] = x[DWORD_W-1-i];
        end
        return y;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
// Request and result channels of the shift sequencer.
//
// Handshake: both channels use strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready. The producer must hold valid and its
// payload stable until that transfer. The consumer may drive ready
// independently of valid.
//
//   request : in_valid, in_ready, in_op[1:0], in_amt[4:0], in_data[31:0]
//             (+ in_left when SHIFT_SEQ_LEFT_EN is defined)
//   result  : out_valid, out_ready, out_data[31:0]
//
// Modports:
//   master - the issuer (ALU issue logic / testbench)
//   slave  - the sequencer
// -----------------------------------------------------------------------------
interface shift_sequencer_if;

    logic                                in_valid;
    logic                                in_ready;
    logic [1:0]                          in_op;
    logic [4:0]                          in_amt;
    logic [shift_seq_pkg::DWORD_W-1:0]   in_data;
`ifdef SHIFT_SEQ_LEFT_EN
    logic                                in_left;
`endif
    logic                                out_valid;
    logic                                out_ready;
    logic [shift_seq_pkg::DWORD_W-1:0]   out_data;

`ifdef SHIFT_SEQ_LEFT_EN
    modport master (
        output in_valid, in_op, in_amt, in_data, in_left, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_op, in_amt, in_data, in_left, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_op, in_amt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_op, in_amt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/shift_sequencer_bit_shifter.sv
// -----------------------------------------------------------------------------
// bit_shifter
// Combinational 16-bit right shifter: dout[i] = din[i+shamt] while
// i+shamt < 16. Beyond that the fill comes from the wrapped input
// (rotate=1), from din[15] (arith=1), or is zero.
//
// Ports:
//   din[15:0]   operand
//   shamt[3:0]  shift distance 0..15
//   rotate      wrap bits shifted out back in at the top
//   arith       sign fill (ignored when rotate=1)
//   dout[15:0]  result
// -----------------------------------------------------------------------------
module bit_shifter
    import shift_seq_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    input  logic [3:0]        shamt,
    input  logic              rotate,
    input  logic              arith,
    output logic [WORD_W-1:0] dout
);

    logic [2*WORD_W-1:0] ext;

    always_comb begin
        ext = '0;
        ext[WORD_W-1:0] = din;
        if (rotate) begin
            ext[2*WORD_W-1:WORD_W] = din;
        end else if (arith) begin
            ext[2*WORD_W-1:WORD_W] = {WORD_W{din[WORD_W-1]}};
        end
        dout = WORD_W'(ext >> shamt);
    end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle 32-bit right shifter (logical / arithmetic / rotate) built by
// time-multiplexing one 16-bit bit_shifter, always used in rotate mode.
// The amount splits into a word select (amt[4]) applied at accept and a
// 0..15 funnel step (amt[3:0]) applied to two words on consecutive cycles.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (aborts any in-flight request)
//   bus        shift_sequencer_if.slave (request and result channels)
//   busy       high whenever the FSM is not IDLE
//   dbg_state  current FSM state
//
// Parameters:
//   ZERO_FAST  1: amt==0 bypasses the shifter and is in DONE after the
//              accept edge. 0: every request runs IDLE->S_A->S_B->DONE.
//
// Optional feature (macro SHIFT_SEQ_LEFT_EN): adds bus.in_left. A left
// request bit-reverses the operand on accept and the result on entry to
// DONE; sign fill is suppressed so arithmetic-left equals logical-left.
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_sequencer_if.slave     bus,
    output logic                 busy,
    output state_e               dbg_state
);

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    a_q, a_d;     // first word through the shifter
    logic [WORD_W-1:0]    b_q, b_d;     // second word through the shifter
    logic [WORD_W-1:0]    c_q, c_d;     // word that feeds the top bits of hi
    logic [WORD_W-1:0]    ra_q, ra_d;   // rotr(A, r) captured in S_A
    logic [3:0]           r_q, r_d;
    logic                 rot_q, rot_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic [DWORD_W-1:0]   out_data_q, out_data_d;
`ifdef SHIFT_SEQ_LEFT_EN
    logic                 left_q, left_d;
`endif

    logic [WORD_W-1:0]    sh_in;
    logic [WORD_W-1:0]    sh_out;

    assign sh_in = (state_q == S_B) ? b_q : a_q;

    bit_shifter u_shifter (
        .din    (sh_in),
        .shamt  (r_q),
        .rotate (1'b1),
        .arith  (1'b0),
        .dout   (sh_out)
    );

    always_comb begin
        logic [DWORD_W-1:0] opnd;
        logic [WORD_W-1:0]  fill;
        logic [WORD_W-1:0]  mask;
        logic [WORD_W-1:0]  rb;
        logic [WORD_W-1:0]  rc;
        logic [DWORD_W-1:0] result;
        logic               left_now;
        logic               is_rot;

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        ra_d        = ra_q;
        r_d         = r_q;
        rot_d       = rot_q;
        out_data_d  = out_data_q;
`ifdef SHIFT_SEQ_LEFT_EN
        left_d      = left_q;
`endif

        left_now = 1'b0;
        opnd     = bus.in_data;
`ifdef SHIFT_SEQ_LEFT_EN
        left_now = bus.in_left;
        if (left_now) begin
            opnd = bit_rev32(bus.in_data);
        end
`endif
        is_rot = (bus.in_op == SHIFT_OP_ROR);
        // Sign fill only for a right arithmetic shift; reserved op 2'b11 is logical.
        fill   = (bus.in_op == SHIFT_OP_ASR && !left_now) ? {WORD_W{opnd[DWORD_W-1]}} : '0;

        // Top r bits of each result word come from the next-higher word.
        mask   = ~(16'hFFFF >> r_q);
        rb     = sh_out;
        // C is A's word in rotate mode (so rotr(C) == RA); otherwise C is
        // the fill word, which is invariant under rotation.
        rc     = rot_q ? ra_q : c_q;
        result = {(rb & ~mask) | (rc & mask), (ra_q & ~mask) | (rb & mask)};
`ifdef SHIFT_SEQ_LEFT_EN
        if (left_q) begin
            result = bit_rev32(result);
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    r_d   = bus.in_amt[3:0];
                    rot_d = is_rot;
`ifdef SHIFT_SEQ_LEFT_EN
                    left_d = left_now;
`endif
                    case ({is_rot, bus.in_amt[4]})
                        2'b10:   begin a_d = opnd[15:0];  b_d = opnd[31:16]; c_d = opnd[15:0];  end
                        2'b11:   begin a_d = opnd[31:16]; b_d = opnd[15:0];  c_d = opnd[31:16]; end
                        2'b00:   begin a_d = opnd[15:0];  b_d = opnd[31:16]; c_d = fill;        end
                        default: begin a_d = opnd[31:16]; b_d = fill;        c_d = fill;        end
                    endcase
                    if (ZERO_FAST && bus.in_amt == 5'd0) begin
                        // Zero shift is the identity for every op and direction.
                        out_data_d = bus.in_data;
                        state_d    = DONE;
                    end else begin
                        state_d    = S_A;
                    end
                end
            end
            S_A: begin
                ra_d    = sh_out;
                state_d = S_B;
            end
            S_B: begin
                out_data_d = result;
                state_d    = DONE;
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Handshake outputs are registered copies derived from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ra_q        <= '0;
            r_q         <= '0;
            rot_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
`ifdef SHIFT_SEQ_LEFT_EN
            left_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ra_q        <= ra_d;
            r_q         <= r_d;
            rot_q       <= rot_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
`ifdef SHIFT_SEQ_LEFT_EN
            left_q      <= left_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule
